// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   Registered 1-to-N stream demultiplexer with valid/ready handshaking.
//   Each accepted input beat is routed to the channel given by in_sel. It
//   lands in a single output buffer, so y_valid rises one cycle after the
//   accept. With LOCK=1, the channel chosen on the first beat of a packet is
//   held until the beat carrying in_last. Beats aimed at a channel that does
//   not exist are consumed and dropped. Each drop raises a one-cycle err pulse
//   and bumps a saturating drop counter.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_data   in   [WIDTH-1:0]       input beat data
//   in_sel    in   [SEL_W-1:0]       destination channel
//   in_last   in   final beat of packet
//   in_valid  in   beat offered
//   in_ready  out  beat accepted when in_valid && in_ready
//   y_data    out  [N_CH*WIDTH-1:0]  channel i at bits [i*WIDTH +: WIDTH]
//   y_last    out  [N_CH-1:0]        per-channel last flag
//   y_valid   out  [N_CH-1:0]        per-channel valid
//   y_ready   in   [N_CH-1:0]        per-channel ready
//   err       out  one-cycle pulse per dropped beat
//   drop_cnt  out  [7:0]             saturating count of dropped beats
// -----------------------------------------------------------------------------
module stream_demux #(
   parameter int WIDTH     = 8,
   parameter int N_CH      = 4,
   parameter int SEL_W     = 2,
   parameter int LOCK      = 1,
   parameter int ZERO_IDLE = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WIDTH-1:0]        in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_last,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [N_CH*WIDTH-1:0]   y_data,
   output logic [N_CH-1:0]         y_last,
   output logic [N_CH-1:0]         y_valid,
   input  logic [N_CH-1:0]         y_ready,
   output logic                    err,
   output logic [7:0]              drop_cnt
);

   typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
   logic               buf_valid_q, buf_valid_d;
   logic [WIDTH-1:0]   buf_data_q, buf_data_d;
   logic [SEL_W-1:0]   buf_ch_q, buf_ch_d;
   logic               buf_last_q, buf_last_d;
   logic               err_q, err_d;
   logic [7:0]         drop_cnt_q, drop_cnt_d;

   logic               drained;
   logic               accept;
   logic               in_range;
   logic [SEL_W-1:0]   eff_ch;
   logic               hit;

   // Only the ready of the channel currently holding the buffered beat matters.
   always_comb begin
      drained = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (buf_ch_q == SEL_W'(i) && y_ready[i]) drained = 1'b1;
      end
      drained = drained && buf_valid_q;
   end

   assign in_ready = !buf_valid_q || drained;
   assign accept   = in_valid && in_ready;
   assign eff_ch   = (LOCK != 0 && state_q == ST_LOCKED) ? lock_ch_q : in_sel;
   assign in_range = int'(eff_ch) < N_CH;

   // Buffer, error and drop counter next state. A drain and a load in the
   // same cycle leave buf_valid at 1, so back-to-back beats have no bubble.
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_data_d  = buf_data_q;
      buf_ch_d    = buf_ch_q;
      buf_last_d  = buf_last_q;
      err_d       = 1'b0;
      drop_cnt_d  = drop_cnt_q;
      if (drained) buf_valid_d = 1'b0;
      if (accept) begin
         if (in_range) begin
            buf_valid_d = 1'b1;
            buf_data_d  = in_data;
            buf_ch_d    = eff_ch;
            buf_last_d  = in_last;
         end else begin
            err_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end
   end

   // Packet lock FSM. Locking onto a nonexistent channel is allowed; the rest
   // of that packet is then dropped beat by beat.
   always_comb begin
      state_d   = state_q;
      lock_ch_d = lock_ch_q;
      if (LOCK != 0 && accept) begin
         case (state_q)
            ST_OPEN: begin
               if (!in_last) begin
                  state_d   = ST_LOCKED;
                  lock_ch_d = in_sel;
               end
            end
            ST_LOCKED: begin
               if (in_last) state_d = ST_OPEN;
            end
            default: state_d = ST_OPEN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_OPEN;
         lock_ch_q   <= '0;
         buf_valid_q <= 1'b0;
         buf_data_q  <= '0;
         buf_ch_q    <= '0;
         buf_last_q  <= 1'b0;
         err_q       <= 1'b0;
         drop_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         lock_ch_q   <= lock_ch_d;
         buf_valid_q <= buf_valid_d;
         buf_data_q  <= buf_data_d;
         buf_ch_q    <= buf_ch_d;
         buf_last_q  <= buf_last_d;
         err_q       <= err_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Output fan-out. With ZERO_IDLE=0 the buffered data is broadcast and only
   // y_valid marks the owning channel.
   always_comb begin
      y_valid = '0;
      y_last  = '0;
      y_data  = '0;
      hit     = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         hit        = (buf_ch_q == SEL_W'(i));
         y_valid[i] = buf_valid_q && hit;
         y_last[i]  = buf_valid_q && hit && buf_last_q;
         if (ZERO_IDLE == 0 || hit) y_data[i*WIDTH +: WIDTH] = buf_data_q;
      end
   end

   assign err      = err_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking. It generalises the four-way combinational demux to WIDTH-bit data, N_CH channels, one pipeline register, and optional packet-locked routing. Each input beat is routed to the channel chosen by the select input. In lock mode, the channel is held for a whole packet. It sits between a single producer and N independent consumers.

Parameters:
WIDTH, 8, data width in bits
N_CH, 4, number of output channels (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= N_CH
LOCK, 1, 1 = select sampled on first beat of packet and held until in_last; 0 = select sampled every beat
ZERO_IDLE, 1, 1 = unselected channel data forced to 0; 0 = buffered data broadcast on all channels

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_data  in  WIDTH  input beat data
in_sel  in  SEL_W  destination channel
in_last  in  1  final beat of packet
in_valid  in  1  beat offered
in_ready  out  1  beat accepted when in_valid && in_ready
y_data  out  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
y_last  out  N_CH  per-channel last flag
y_valid  out  N_CH  per-channel valid
y_ready  in  N_CH  per-channel ready
err  out  1  one-cycle pulse when a beat is dropped for an out-of-range channel
drop_cnt  out  8  saturating count of dropped beats

Behaviour:
- Reset (async assert, sync release): buf_valid=0, buf_data=0, buf_ch=0, buf_last=0, state=OPEN, lock_ch=0, err=0, drop_cnt=0. All y_valid=0, all y_data=0, all y_last=0.
- A reset asserted mid-packet discards any buffered beat and unlocks. No beat is emitted after release until a new accept occurs.
- Single output register (buf_*) gives a latency of 1 cycle from accept to the y_valid assertion.
- in_ready = !buf_valid || y_ready[buf_ch]. This is combinational and allows full throughput of 1 beat/cycle.
- Accept (in_valid && in_ready):
  - eff_ch = lock_ch when state==LOCKED, else in_sel.
  - If eff_ch < N_CH: load buf_data, buf_last and buf_ch=eff_ch, and set buf_valid=1.
  - If eff_ch >= N_CH: beat is consumed but not buffered. err pulses 1 for the next cycle. drop_cnt increments and saturates at 255. buf_valid is cleared if its current beat was drained this cycle.
- No accept and the buffered beat drained (y_ready[buf_ch]): buf_valid becomes 0.
- Outputs:
  - y_valid[i] = buf_valid && buf_ch==i.
  - y_last[i] = y_valid[i] && buf_last.
  - y_data slice i = buf_data when ZERO_IDLE==0 or buf_ch==i, else 0.
- y_ready of non-selected channels is ignored. y_valid of a channel stays asserted with stable data until that channel's ready is high.
- State machine (LOCK=1 only; with LOCK=0, state stays OPEN):
  - OPEN: on accept with in_last=0, lock_ch=in_sel and state becomes LOCKED. On accept with in_last=1, stay OPEN (single-beat packet).
  - LOCKED: in_sel is ignored. On accept with in_last=1, state becomes OPEN.
  - Locking onto an out-of-range channel is legal. The whole packet is dropped beat by beat, with err and drop_cnt advancing on each beat.
- Simultaneous drain and accept in the same cycle: buffer reloads, and buf_valid stays 1 with no bubble.
- A change of in_sel while in_valid=1 and in_ready=0 takes effect only on the accepting cycle.

Test Plan:
- Reset, then with LOCK=0 send 4 single beats (data 0xA0..0xA3, sel 0..3), all y_ready=1. Required: y_valid one-hot 0001, 0010, 0100, 1000 on consecutive cycles, each 1 cycle after accept, with matching data. Unselected slices are 0 when ZERO_IDLE=1.
- Backpressure: sel=2, data 0x55, y_ready[2]=0 for 3 cycles while y_ready[0]=1. Required: y_valid[2] held with data 0x55, in_ready=0 from the second beat until y_ready[2]=1, and no beat appears on channel 0.
- LOCK=1, 3-beat packet with in_sel driven 1, 3, 0 (last on beat 3). Required: all three beats arrive on channel 1, y_last[1]=1 only on beat 3, and a following single beat with sel=3 arrives on channel 3.
- N_CH=3 with sel=3, 2-beat packet, LOCK=1. Required: no y_valid, err pulses on 2 cycles, drop_cnt=2. Repeat 300 beats: drop_cnt saturates at 255.
- Streaming 8 beats, sel=0, y_ready[0]=1 continuously. Required: in_ready stays 1 and 8 consecutive y_valid[0] cycles with no bubble.
- Assert rst_n=0 asynchronously in LOCKED state with a buffered beat. Required: y_valid=0 immediately. After release, a beat with sel=2 routes to channel 2 (lock cleared).
